// File: rtl/task_op_issuer_if.sv
// Host command channel of task_op_issuer.
// Handshake: a command transfers on a rising clock edge where cmd_valid and cmd_ready are both high.
interface task_op_issuer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_task;
  logic [3:0] cmd_op;
  logic [3:0] cmd_arg;

  modport master (output cmd_valid, cmd_task, cmd_op, cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, cmd_task, cmd_op, cmd_arg, output cmd_ready);
endinterface

// File: rtl/task_op_issuer.sv
// Drives per-task op words: host commands plus one Execute per timeslice to the sorter winner.
// Optional feature macro: KILL_ALL_EN (broadcast Kill-overall on a rising edge of kill_all).
module task_op_issuer #(
  parameter int NUM_TASKS = 4,
  parameter int SLICE     = 10000,
  parameter int HOLD_CYC  = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [7:0]             in_winner,
  task_op_issuer_if.slave        cmd,
`ifdef KILL_ALL_EN
  input  logic                   kill_all,
`endif
  output logic [16*NUM_TASKS-1:0] out_op_bus,
  output logic                   cmd_err,
  output logic                   busy,
  output logic [15:0]            exe_issued,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_GAP} state_t;

  localparam int             SW         = (SLICE > 1) ? $clog2(SLICE) : 1;
  localparam logic [SW-1:0]  SLICE_LAST = SW'(SLICE - 1);
  localparam logic [3:0]     HOLD_LAST  = 4'(HOLD_CYC - 1);
  localparam logic [3:0]     NT4        = 4'(NUM_TASKS);
  localparam logic [15:0]    EXE_WORD   = 16'h0170;
  localparam logic [15:0]    KILL_WORD  = 16'h01C0;

  state_t                 r_state, w_state_nxt;
  logic [SW-1:0]          r_slice;
  logic                   r_pend_exe;
  logic [3:0]             r_hold;
  logic [3:0]             r_tgt;
  logic [15:0]            r_word;
  logic                   r_all;
  logic                   r_is_exe;
  logic                   w_pend_kill;
  logic                   w_ready, w_hs, w_op_ok, w_task_ok, w_win_ok;
  logic                   w_latch_cmd, w_latch_exe, w_latch_kill, w_clr_exe, w_drop;
  logic                   w_tc, w_kill_issue;
  logic [3:0]             w_arg;
  logic [16*NUM_TASKS-1:0] w_drive;
  logic                   w_unused_prio;

  // Winner priority is the sorter's business; only the id is used here.
  assign w_unused_prio = ^in_winner[7:4];

  assign w_hs      = cmd.cmd_valid && w_ready;
  assign w_op_ok   = (cmd.cmd_op inside {[4'h1:4'h7], 4'hC});
  assign w_task_ok = (cmd.cmd_task != 4'h0) && (cmd.cmd_task <= NT4);
  assign w_win_ok  = (in_winner[3:0] != 4'h0) && (in_winner[3:0] <= NT4);
  assign w_arg     = (cmd.cmd_op == 4'h5 || cmd.cmd_op == 4'h6) ? cmd.cmd_arg : 4'h0;
  assign w_tc      = (r_slice == SLICE_LAST);
  assign w_kill_issue = (r_state == S_ISSUE) && r_all;

  assign cmd.cmd_ready = w_ready && !RST;
  assign busy          = (r_state != S_IDLE);
  assign dbg_state     = r_state;

`ifdef KILL_ALL_EN
  logic r_kill_d, r_pend_kill;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_kill_d    <= 1'b0;
      r_pend_kill <= 1'b0;
    end else begin
      r_kill_d <= kill_all;
      if (kill_all && !r_kill_d) r_pend_kill <= 1'b1;
      else if (w_latch_kill)     r_pend_kill <= 1'b0;
    end
  end

  assign w_pend_kill = r_pend_kill;
`else
  assign w_pend_kill = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_ready      = 1'b0;
    w_latch_cmd  = 1'b0;
    w_latch_exe  = 1'b0;
    w_latch_kill = 1'b0;
    w_clr_exe    = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = !w_pend_kill;
        if (w_pend_kill) begin
          w_latch_kill = 1'b1;
          w_state_nxt  = S_ISSUE;
        end else if (w_hs) begin
          // A dropped command still consumes this IDLE cycle; the slice Execute waits one cycle.
          if (w_op_ok && w_task_ok) begin
            w_latch_cmd = 1'b1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_drop = 1'b1;
          end
        end else if (r_pend_exe) begin
          w_clr_exe = 1'b1;
          if (w_win_ok) begin
            w_latch_exe = 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: w_state_nxt = S_HOLD;
      S_HOLD:  if (r_hold == 4'h0) w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_drive = '0;
    for (int i = 0; i < NUM_TASKS; i++) begin
      if (r_all || (r_tgt == 4'(i + 1))) w_drive[16*i +: 16] = r_word;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_slice    <= '0;
      r_pend_exe <= 1'b0;
      r_hold     <= 4'h0;
      r_tgt      <= 4'h0;
      r_word     <= 16'h0000;
      r_all      <= 1'b0;
      r_is_exe   <= 1'b0;
      exe_issued <= 16'h0000;
      cmd_err    <= 1'b0;
      out_op_bus <= '0;
    end else begin
      if (w_kill_issue || w_tc) r_slice <= '0;
      else                      r_slice <= r_slice + 1'b1;

      // A fresh terminal count wins over the IDLE clear; a kill-all restarts the slice.
      if (w_kill_issue)   r_pend_exe <= 1'b0;
      else if (w_tc)      r_pend_exe <= 1'b1;
      else if (w_clr_exe) r_pend_exe <= 1'b0;

      if (w_latch_cmd) begin
        r_tgt    <= cmd.cmd_task;
        r_word   <= {8'h01, cmd.cmd_op, w_arg};
        r_all    <= 1'b0;
        r_is_exe <= (cmd.cmd_op == 4'h7);
      end else if (w_latch_exe) begin
        r_tgt    <= in_winner[3:0];
        r_word   <= EXE_WORD;
        r_all    <= 1'b0;
        r_is_exe <= 1'b1;
      end else if (w_latch_kill) begin
        r_tgt    <= 4'h0;
        r_word   <= KILL_WORD;
        r_all    <= 1'b1;
        r_is_exe <= 1'b0;
      end

      if (r_state == S_ISSUE)                       r_hold <= HOLD_LAST;
      else if (r_state == S_HOLD && r_hold != 4'h0) r_hold <= r_hold - 4'h1;

      if (r_state == S_ISSUE && r_is_exe) exe_issued <= exe_issued + 16'h0001;

      cmd_err    <= w_drop;
      // Bus is registered so the word is visible exactly for the HOLD cycles.
      out_op_bus <= (w_state_nxt == S_HOLD) ? w_drive : '0;
    end
  end

endmodule

// File: tb/tb_task_op_issuer.sv
// Scoreboard bench for task_op_issuer: directed commands and slice Executes, monitor checks every bus word.
module tb_task_op_issuer;
  localparam int NT = 4;
  localparam int SL = 8;
  localparam int HC = 2;
  localparam int BW = 16 * NT;

  logic          CLK;
  logic          RST;
  logic [7:0]    in_winner;
  logic [BW-1:0] out_op_bus;
  logic          cmd_err;
  logic          busy;
  logic [15:0]   exe_issued;
  logic [1:0]    dbg_state;
`ifdef KILL_ALL_EN
  logic          kill_all;
`endif

  task_op_issuer_if cif ();

  task_op_issuer #(.NUM_TASKS(NT), .SLICE(SL), .HOLD_CYC(HC)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_winner  (in_winner),
    .cmd        (cif),
`ifdef KILL_ALL_EN
    .kill_all   (kill_all),
`endif
    .out_op_bus (out_op_bus),
    .cmd_err    (cmd_err),
    .busy       (busy),
    .exe_issued (exe_issued),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [BW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;
  int exp_err  = 0;

  function automatic logic [BW-1:0] mk(input int idx, input logic [15:0] w);
    logic [BW-1:0] v;
    v = '0;
    v[16*(idx-1) +: 16] = w;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // monitor
  logic [BW-1:0] prev_bus = '0;
  logic [BW-1:0] exp_w;
  int            run_len = 0;

  always @(negedge CLK) begin
    if (cmd_err === 1'b1) err_seen++;
    if (RST) begin
      prev_bus = '0;
      run_len  = 0;
    end else begin
      if (out_op_bus != '0) begin
        if (prev_bus == '0) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_word: got %h expected none", out_op_bus);
          end else begin
            exp_w = exp_q.pop_front();
            if (out_op_bus !== exp_w) begin
              n_errors++;
              $display("FAIL bus_word: got %h expected %h", out_op_bus, exp_w);
            end
          end
          run_len = 1;
        end else begin
          if (out_op_bus !== prev_bus) begin
            n_checks++;
            n_errors++;
            $display("FAIL word_changed: got %h expected %h", out_op_bus, prev_bus);
          end
          run_len++;
        end
      end else if (prev_bus != '0) begin
        n_checks++;
        if (run_len != HC) begin
          n_errors++;
          $display("FAIL hold_len: got %0d expected %0d", run_len, HC);
        end
      end
      prev_bus = out_op_bus;
    end
  end

  // driver
  task automatic send_cmd(input logic [3:0] t, input logic [3:0] op, input logic [3:0] arg);
    bit acc;
    acc = 1'b0;
    @(negedge CLK);
    cif.cmd_valid = 1'b1;
    cif.cmd_task  = t;
    cif.cmd_op    = op;
    cif.cmd_arg   = arg;
    for (int i = 0; i < 40 && !acc; i++) begin
      if (cif.cmd_ready) begin
        @(posedge CLK);
        acc = 1'b1;
      end else begin
        @(negedge CLK);
      end
    end
    #1 cif.cmd_valid = 1'b0;
    chk("cmd_accept", {63'b0, acc}, 64'd1);
  endtask

  typedef struct { logic [3:0] t; logic [3:0] op; } drop_t;
  drop_t drops[6];

  int   busy_cnt;
  int   t_prev;
  logic [15:0] last_exe;
  bit   seen;

  initial begin
    RST           = 1'b1;
    in_winner     = 8'h00;
    cif.cmd_valid = 1'b0;
    cif.cmd_task  = 4'h0;
    cif.cmd_op    = 4'h0;
    cif.cmd_arg   = 4'h0;
`ifdef KILL_ALL_EN
    kill_all      = 1'b0;
`endif
    drops[0] = '{4'h0, 4'h2};
    drops[1] = '{4'h1, 4'hF};
    drops[2] = '{4'h5, 4'h1};
    drops[3] = '{4'h2, 4'h8};
    drops[4] = '{4'h2, 4'h0};
    drops[5] = '{4'h3, 4'hD};

    repeat (3) @(negedge CLK);
    chk("rst_bus", 64'(out_op_bus), 64'd0);
    chk("rst_ready", {63'b0, cif.cmd_ready}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_err", {63'b0, cmd_err}, 64'd0);
    chk("rst_exe", {48'b0, exe_issued}, 64'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("ready_after_rst", {63'b0, cif.cmd_ready}, 64'd1);

    // Suspend to task 2: one ISSUE cycle with idle bus, then busy 4 cycles total
    exp_q.push_back(mk(2, 16'h0120));
    send_cmd(4'd2, 4'h2, 4'h0);
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (!busy) break;
      if (i == 0) chk("issue_cycle_bus", 64'(out_op_bus), 64'd0);
      busy_cnt++;
    end
    chk("busy_len", 64'(busy_cnt), 64'd4);

    // back-to-back identical Priority commands must be separated by a gap
    exp_q.push_back(mk(1, 16'h015A));
    exp_q.push_back(mk(1, 16'h015A));
    send_cmd(4'd1, 4'h5, 4'hA);
    send_cmd(4'd1, 4'h5, 4'hA);
    exp_q.push_back(mk(4, 16'h0110));
    send_cmd(4'd4, 4'h1, 4'hF);
    exp_q.push_back(mk(3, 16'h01C0));
    send_cmd(4'd3, 4'hC, 4'h5);
    exp_q.push_back(mk(2, 16'h0170));
    send_cmd(4'd2, 4'h7, 4'h3);
    repeat (8) @(negedge CLK);
    chk("exe_after_cmd", {48'b0, exe_issued}, 64'd1);

    // dropped commands
    foreach (drops[k]) begin
      send_cmd(drops[k].t, drops[k].op, 4'h6);
      exp_err++;
      @(negedge CLK);
      chk("drop_err_pulse", {63'b0, cmd_err}, 64'd1);
      chk("drop_not_busy", {63'b0, busy}, 64'd0);
      @(negedge CLK);
      chk("drop_err_clear", {63'b0, cmd_err}, 64'd0);
    end

    // out-of-range and empty winner: silent skip
    in_winner = 8'h37;
    repeat (20) @(negedge CLK);
    chk("skip_oor_exe", {48'b0, exe_issued}, 64'd1);
    in_winner = 8'h00;
    repeat (10) @(negedge CLK);
    chk("skip_zero_exe", {48'b0, exe_issued}, 64'd1);

    // slice Execute to winner 3, once every SL cycles
    repeat (3) exp_q.push_back(mk(3, 16'h0170));
    in_winner = 8'h53;
    last_exe  = exe_issued;
    t_prev    = 0;
    for (int k = 0; k < 3; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge CLK);
        if (exe_issued != last_exe) seen = 1'b1;
      end
      chk("slice_exe_seen", {63'b0, seen}, 64'd1);
      if (k > 0) chk("slice_interval", 64'(cyc - t_prev), 64'(SL));
      t_prev   = cyc;
      last_exe = exe_issued;
    end
    in_winner = 8'h00;
    repeat (12) @(negedge CLK);
    chk("slice_exe_total", {48'b0, exe_issued}, 64'd4);

`ifdef KILL_ALL_EN
    // kill_all during HOLD: current word completes, then broadcast
    exp_q.push_back(mk(4, 16'h0120));
    exp_q.push_back({NT{16'h01C0}});
    send_cmd(4'd4, 4'h2, 4'h0);
    @(negedge CLK);
    @(negedge CLK);
    kill_all = 1'b1;
    @(negedge CLK);
    kill_all = 1'b0;
    repeat (14) @(negedge CLK);
    chk("kill_idle", {63'b0, busy}, 64'd0);
`endif

    // async reset mid-HOLD: bus clears immediately, nothing replayed
    exp_q.push_back(mk(1, 16'h0130));
    send_cmd(4'd1, 4'h3, 4'h0);
    @(negedge CLK);
    @(negedge CLK);
    #1 RST = 1'b1;
    #1;
    chk("async_rst_bus", 64'(out_op_bus), 64'd0);
    chk("async_rst_busy", {63'b0, busy}, 64'd0);
    chk("async_rst_ready", {63'b0, cif.cmd_ready}, 64'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    chk("async_rst_exe", {48'b0, exe_issued}, 64'd0);
    repeat (20) @(negedge CLK);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("err_pulses", 64'(err_seen), 64'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
